// File: rtl/rdn_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rdn_pkg : shared types and constants for the RDN weight loader
// Rev 1.0
// ---------------------------------------------------------------------------
package rdn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } rdn_wt_state_t;

  typedef enum logic [1:0] {
    LAYER_A = 2'd0,
    LAYER_B = 2'd1,
    LAYER_C = 2'd2
  } rdn_layer_t;

  localparam int c_beat_words = 32;
  localparam int c_word_w     = 16;
  localparam int c_a_slots    = 401;
  localparam int c_bc_slots   = 16;

  function automatic int rdn_total_words(input int na, input int nb, input int nc,
                                         input int a_slots, input int b_slots,
                                         input int c_slots);
    return na * a_slots + nb * b_slots + nc * c_slots;
  endfunction

  localparam int c_total_words =
    rdn_total_words(15, 15, 36, c_a_slots, c_bc_slots, c_bc_slots);

endpackage
`default_nettype wire

// File: rtl/rdn_wt_cursor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rdn_wt_cursor : slot / neuron / layer nested counters for the weight stream
// Rev 1.0
// ---------------------------------------------------------------------------
module rdn_wt_cursor
  import rdn_pkg::*;
#(
  parameter int NUM_A_NEURONS = 15,
  parameter int NUM_B_NEURONS = 15,
  parameter int NUM_C_NEURONS = 36,
  parameter int A_SLOTS       = c_a_slots,
  parameter int B_SLOTS       = c_bc_slots,
  parameter int C_SLOTS       = c_bc_slots
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output rdn_layer_t layer,
  output logic [5:0] neuron_sel,
  output logic [8:0] weight_sel,
  output logic       last
);

  rdn_layer_t r_layer;
  rdn_layer_t w_layer_nxt;
  logic [5:0] r_neuron;
  logic [5:0] w_neuron_max;
  logic [8:0] r_slot;
  logic [8:0] w_slot_max;
  logic       w_slot_wrap;
  logic       w_neuron_wrap;

  always_comb begin
    w_slot_max   = 9'(A_SLOTS - 1);
    w_neuron_max = 6'(NUM_A_NEURONS - 1);
    w_layer_nxt  = LAYER_B;
    case (r_layer)
      LAYER_B: begin
        w_slot_max   = 9'(B_SLOTS - 1);
        w_neuron_max = 6'(NUM_B_NEURONS - 1);
        w_layer_nxt  = LAYER_C;
      end
      LAYER_C: begin
        w_slot_max   = 9'(C_SLOTS - 1);
        w_neuron_max = 6'(NUM_C_NEURONS - 1);
        w_layer_nxt  = LAYER_A;
      end
      default: ;
    endcase
  end

  assign w_slot_wrap   = (r_slot == w_slot_max);
  assign w_neuron_wrap = (r_neuron == w_neuron_max);
  assign last          = (r_layer == LAYER_C) && w_slot_wrap && w_neuron_wrap;
  assign layer         = r_layer;
  assign neuron_sel    = r_neuron;
  assign weight_sel    = r_slot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_layer  <= LAYER_A;
      r_neuron <= '0;
      r_slot   <= '0;
    end else if (clr) begin
      r_layer  <= LAYER_A;
      r_neuron <= '0;
      r_slot   <= '0;
    end else if (inc) begin
      if (!w_slot_wrap) begin
        r_slot <= r_slot + 9'd1;
      end else begin
        r_slot <= '0;
        if (!w_neuron_wrap) begin
          r_neuron <= r_neuron + 6'd1;
        end else begin
          r_neuron <= '0;
          r_layer  <= w_layer_nxt;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rdn_wt_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rdn_wt_loader : streams 32-word memory beats into the A/B/C neuron slots
// Rev 1.0
// ---------------------------------------------------------------------------
module rdn_wt_loader
  import rdn_pkg::*;
#(
  parameter int NUM_A_NEURONS = 15,
  parameter int NUM_B_NEURONS = 15,
  parameter int NUM_C_NEURONS = 36,
  parameter int A_WEIGHTS     = 400,
  parameter int B_WEIGHTS     = NUM_A_NEURONS,
  parameter int C_WEIGHTS     = NUM_B_NEURONS
)(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   go,
  input  logic                                   mem_ready,
  input  logic [c_beat_words-1:0][c_word_w-1:0]  mem_data,
  output logic                                   req_mem,
  output logic                                   write_a,
  output logic                                   write_b,
  output logic                                   write_c,
  output logic [5:0]                             neuron_sel,
  output logic [8:0]                             weight_sel,
  output logic signed [c_word_w-1:0]             weight_bus,
  output logic                                   weight_valid
);

  localparam int c_k_w = $clog2(c_beat_words);
  localparam logic [c_k_w-1:0] c_k_last = c_k_w'(c_beat_words - 1);

  rdn_wt_state_t r_state;
  rdn_wt_state_t w_state_nxt;

  logic [c_beat_words-1:0][c_word_w-1:0] r_beat;
  logic [c_k_w-1:0]    r_k;
  logic [c_k_w-1:0]    w_k_nxt;
  logic                r_last_wr;
  rdn_layer_t          w_layer;
  logic [5:0]          w_cur_neuron;
  logic [8:0]          w_cur_slot;
  logic                w_cur_last;
  logic                w_clr;
  logic                w_capture;
  logic                w_present;
  logic [c_word_w-1:0] w_word;

  rdn_wt_cursor #(
    .NUM_A_NEURONS (NUM_A_NEURONS),
    .NUM_B_NEURONS (NUM_B_NEURONS),
    .NUM_C_NEURONS (NUM_C_NEURONS),
    .A_SLOTS       (A_WEIGHTS + 1),
    .B_SLOTS       (B_WEIGHTS + 1),
    .C_SLOTS       (C_WEIGHTS + 1)
  ) u_cursor (
    .clk        (clk),
    .rst        (rst),
    .clr        (w_clr),
    .inc        (w_present),
    .layer      (w_layer),
    .neuron_sel (w_cur_neuron),
    .weight_sel (w_cur_slot),
    .last       (w_cur_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // r_k indexes the word currently on the outputs; r_last_wr marks it as the stream's final word
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (go) w_state_nxt = ST_REQ;
      ST_REQ:           if (mem_ready) w_state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (r_last_wr)          w_state_nxt = ST_DONE;
        else if (r_k == c_k_last) w_state_nxt = ST_REQ;
      end
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // The first word of a beat bypasses the beat register so it lands the cycle after capture
  always_comb begin
    w_clr     = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && go;
    w_capture = (r_state == ST_REQ) && mem_ready;
    w_present = w_capture || ((r_state == ST_WRITE) && !r_last_wr && (r_k != c_k_last));
    w_k_nxt   = r_k + c_k_w'(1);
    w_word    = w_capture ? mem_data[0] : r_beat[w_k_nxt];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_mem      <= 1'b0;
      write_a      <= 1'b0;
      write_b      <= 1'b0;
      write_c      <= 1'b0;
      neuron_sel   <= '0;
      weight_sel   <= '0;
      weight_bus   <= '0;
      weight_valid <= 1'b0;
      r_beat       <= '0;
      r_k          <= '0;
      r_last_wr    <= 1'b0;
    end else begin
      req_mem      <= (w_state_nxt == ST_REQ);
      weight_valid <= (w_state_nxt == ST_DONE);
      write_a      <= w_present && (w_layer == LAYER_A);
      write_b      <= w_present && (w_layer == LAYER_B);
      write_c      <= w_present && (w_layer == LAYER_C);
      if (w_capture) r_beat <= mem_data;
      if (w_clr || w_capture) r_k <= '0;
      else if (w_present)     r_k <= w_k_nxt;
      if (w_present) begin
        neuron_sel <= w_cur_neuron;
        weight_sel <= w_cur_slot;
        weight_bus <= $signed(w_word);
      end
      if (w_clr)          r_last_wr <= 1'b0;
      else if (w_present) r_last_wr <= w_cur_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rdn_wt_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rdn_wt_loader : randomized bench with a stream-order reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rdn_wt_loader;

  localparam int NA     = 15;
  localparam int NB     = 15;
  localparam int NC     = 36;
  localparam int AS     = 401;
  localparam int BS     = 16;
  localparam int CS     = 16;
  localparam int TOTAL  = NA * AS + NB * BS + NC * CS;
  localparam int NBEATS = (TOTAL + 31) / 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go = 1'b0;
  logic mem_ready = 1'b0;
  logic [31:0][15:0] mem_data = '0;
  logic req_mem, write_a, write_b, write_c, weight_valid;
  logic [5:0] neuron_sel;
  logic [8:0] weight_sel;
  logic signed [15:0] weight_bus;

  rdn_wt_loader dut (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .mem_ready    (mem_ready),
    .mem_data     (mem_data),
    .req_mem      (req_mem),
    .write_a      (write_a),
    .write_b      (write_b),
    .write_c      (write_c),
    .neuron_sel   (neuron_sel),
    .weight_sel   (weight_sel),
    .weight_bus   (weight_bus),
    .weight_valid (weight_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stream position of global word n: layer, neuron, slot
  function automatic void map_word(input int n, output int lay, output int nrn, output int slot);
    int m;
    if (n < NA * AS) begin
      lay = 0; nrn = n / AS; slot = n % AS;
    end else if (n < NA * AS + NB * BS) begin
      m = n - NA * AS;
      lay = 1; nrn = m / BS; slot = m % BS;
    end else begin
      m = n - NA * AS - NB * BS;
      lay = 2; nrn = m / CS; slot = m % CS;
    end
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] wdata [TOTAL];
  int  delays    [256];
  int  ready_cyc [256];
  int  req_hi    [256];
  int  n_wr = 0, bcnt = 0, wait_cnt = 0, exp_req_cyc = 0, go_cyc = 0, loads_done = 0;
  bit  m_busy = 0, exp_valid = 0, prev_req = 0, prev_valid = 0, go_req = 0, go_noise = 0;
  int  cnt_a = 0, cnt_b = 0, cnt_c = 0;
  int  last_lay = -1, last_neu = -1, last_slot = -1, last_wr_rel = -1, valid_rise_rel = -1;
  int  obs_a1_bias = -1, obs_b0_bias = -1, obs_c0_w0 = -1;

  // Per-cycle compare, memory responder and go driver
  always @(negedge clk) begin
    int nst, lay, nrn, slot, b, k, act_lay;
    if (rst) begin
      m_busy = 0; n_wr = 0; exp_valid = 0; bcnt = 0; wait_cnt = 0;
      prev_req = 0; prev_valid = 0; go = 1'b0; mem_ready = 1'b0;
    end else begin
      chk("weight_valid", weight_valid, exp_valid);
      if (weight_valid && !prev_valid) valid_rise_rel = cyc - go_cyc;
      if (req_mem && !prev_req) begin
        chk("req_while_busy", m_busy, 1);
        chk("req_rise_cycle", cyc, exp_req_cyc);
      end
      nst = int'(write_a) + int'(write_b) + int'(write_c);
      if (nst != 0) begin
        chk("strobe_onehot", nst, 1);
        chk("strobe_during_req", req_mem, 0);
        chk("strobe_while_busy", m_busy, 1);
        act_lay = write_c ? 2 : (write_b ? 1 : 0);
        if (n_wr >= TOTAL) begin
          chk("extra_strobe", n_wr, TOTAL - 1);
        end else begin
          map_word(n_wr, lay, nrn, slot);
          b = n_wr / 32;
          k = n_wr % 32;
          chk("layer", act_lay, lay);
          chk("neuron_sel", neuron_sel, nrn);
          chk("weight_sel", weight_sel, slot);
          chk("weight_bus", longint'($unsigned(weight_bus)), wdata[n_wr]);
          chk("write_cycle", cyc, ready_cyc[b] + 1 + k);
          if (act_lay == 0) cnt_a++;
          else if (act_lay == 1) cnt_b++;
          else cnt_c++;
          if (write_a && neuron_sel == 6'd1 && weight_sel == 9'd0) obs_a1_bias = int'($unsigned(weight_bus));
          if (write_b && neuron_sel == 6'd0 && weight_sel == 9'd0) obs_b0_bias = int'($unsigned(weight_bus));
          if (write_c && neuron_sel == 6'd0 && weight_sel == 9'd1) obs_c0_w0   = int'($unsigned(weight_bus));
          last_lay = act_lay; last_neu = neuron_sel; last_slot = weight_sel;
          last_wr_rel = cyc - go_cyc;
          if (k == 31 && n_wr + 1 < TOTAL) exp_req_cyc = cyc + 1;
          n_wr++;
          if (n_wr == TOTAL) begin
            m_busy = 0; exp_valid = 1; loads_done++;
          end
        end
      end
      prev_req   = req_mem;
      prev_valid = weight_valid;

      mem_ready = 1'b0;
      for (int w = 0; w < 32; w++) mem_data[w] = 16'($urandom);
      if (req_mem && m_busy && bcnt < NBEATS) begin
        req_hi[bcnt]++;
        if (wait_cnt >= delays[bcnt]) begin
          mem_ready = 1'b1;
          for (int w = 0; w < 32; w++)
            if (bcnt * 32 + w < TOTAL) mem_data[w] = wdata[bcnt * 32 + w];
          ready_cyc[bcnt] = cyc;
          bcnt++;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else if (!req_mem) begin
        mem_ready = 1'($urandom);
      end

      go = 1'b0;
      if (go_req) begin
        go = 1'b1;
        go_req = 0;
        if (!m_busy) begin
          m_busy = 1; n_wr = 0; bcnt = 0; wait_cnt = 0;
          exp_req_cyc = cyc + 1; go_cyc = cyc; exp_valid = 0;
          cnt_a = 0; cnt_b = 0; cnt_c = 0;
          for (int i = 0; i < 256; i++) req_hi[i] = 0;
        end
      end else if (go_noise && m_busy && $urandom_range(0, 7) == 0) begin
        go = 1'b1;
      end
    end
  end

  task automatic check_zero(input string pfx);
    chk({pfx, "_req_mem"}, req_mem, 0);
    chk({pfx, "_write_a"}, write_a, 0);
    chk({pfx, "_write_b"}, write_b, 0);
    chk({pfx, "_write_c"}, write_c, 0);
    chk({pfx, "_neuron_sel"}, neuron_sel, 0);
    chk({pfx, "_weight_sel"}, weight_sel, 0);
    chk({pfx, "_weight_bus"}, longint'($unsigned(weight_bus)), 0);
    chk({pfx, "_weight_valid"}, weight_valid, 0);
  endtask

  task automatic fill_random();
    for (int g = 0; g < TOTAL; g++) wdata[g] = 16'($urandom);
  endtask

  task automatic wait_load();
    int target;
    target = loads_done + 1;
    for (int i = 0; i < 9000 && loads_done < target; i++) @(posedge clk);
    chk("load_complete", loads_done, target);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      delays[i] = 0; ready_cyc[i] = 0; req_hi[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Load aborted by reset during beat 3's write burst
    fill_random();
    go_req = 1;
    for (int i = 0; i < 400 && bcnt < 4; i++) @(posedge clk);
    chk("beat3_reached", bcnt, 4);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_write_a", write_a, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("mid_reset");
    rst = 1'b0;

    // Full load, ready immediate, word value = global index
    for (int g = 0; g < TOTAL; g++) wdata[g] = 16'(g);
    go_req = 1;
    wait_load();
    chk("count_write_a", cnt_a, 6015);
    chk("count_write_b", cnt_b, 240);
    chk("count_write_c", cnt_c, 576);
    chk("last_layer", last_lay, 2);
    chk("last_neuron", last_neu, 35);
    chk("last_slot", last_slot, 15);
    chk("last_write_cycle", last_wr_rel, 7045);
    chk("valid_rise_cycle", valid_rise_rel, 7046);
    chk("a1_bias_value", obs_a1_bias, 401);
    chk("b0_bias_value", obs_b0_bias, 6015);
    chk("c0_w0_value", obs_c0_w0, 6256);

    // Reload from DONE: random data, random stalls, beat 7 stalled 4 cycles, go noise
    fill_random();
    for (int i = 0; i < NBEATS; i++) delays[i] = $urandom_range(0, 3);
    delays[7] = 4;
    go_noise = 1;
    go_req = 1;
    @(posedge clk);
    #1;
    chk("valid_falls_after_go", weight_valid, 0);
    wait_load();
    go_noise = 0;
    chk("beat7_req_cycles", req_hi[7], 5);
    chk("valid_after_reload", weight_valid, 1);

    // One more clean reload
    fill_random();
    for (int i = 0; i < NBEATS; i++) delays[i] = 0;
    go_req = 1;
    wait_load();
    chk("reload_total", cnt_a + cnt_b + cnt_c, 6831);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_wr=%0d", n_wr);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
